hazard_scoreboard: RTL and testbench



---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_delay_line.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and defaults for the decode-stage hazard scoreboard.
//   sb_entry_t         : one in-flight instruction record {valid, we, dst, flags}
//   DEFAULT_WB_LAT     : issue-to-writeback latency in cycles
//   DEFAULT_SQUASH_CNT : wrong-path slots squashed after CALL/RET
//   SB_DST_W           : stored destination width; must be >= ADDR_W of the top
// Optional feature macro: FLAG_TRACK_EN adds a per-slot flag-write bit.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEFAULT_WB_LAT     = 4;
  localparam int DEFAULT_SQUASH_CNT = 3;

  // Destination is stored at a fixed width so the entry type does not depend on
  // the top-level NUM_REGS; narrower addresses are zero-extended on entry.
  localparam int SB_DST_W = 8;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [SB_DST_W-1:0] dst;
`ifdef FLAG_TRACK_EN
    logic                flags;
`endif
  } sb_entry_t;

endpackage

// File: rtl/hazard_delay_line.sv
// -----------------------------------------------------------------------------
// hazard_delay_line
// WB_LAT-deep shift register of scoreboard entries. Shifts every cycle with no
// enable; slot 0 takes the new entry and slot WB_LAT-1 falls off the end.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all slots)
//   entry_in   : entry captured into slot 0 on each rising edge
//   slots      : current contents of all slots, slot 0 youngest
// Optional feature macro: FLAG_TRACK_EN (changes the entry layout only).
// -----------------------------------------------------------------------------
module hazard_delay_line
  import hazard_pkg::*;
#(
  parameter int WB_LAT = DEFAULT_WB_LAT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sb_entry_t entry_in,
  output sb_entry_t slots [WB_LAT]
);

  sb_entry_t slots_q [WB_LAT];
  sb_entry_t slots_d [WB_LAT];

  always_comb begin
    slots_d[0] = entry_in;
    for (int i = 1; i < WB_LAT; i++) begin
      slots_d[i] = slots_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_LAT; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      slots_q <= slots_d;
    end
  end

  assign slots = slots_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage hazard detection using a delay-line scoreboard of in-flight
// register and flag writes. Raises stall on RAW / flag-before-branch hazards
// and squashes SQUASH_CNT wrong-path slots after an accepted CALL/RET.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   issue_valid/we/dst     : ID instruction and its register write
//   issue_sets_flags       : ID instruction writes N/Z/V
//   src0/1_re, src0/1_addr : source register reads
//   is_branch              : conditional branch (reads flags)
//   redirect               : CALL/RET
//   icache_stall           : fetch miss, forces stall and freezes squash count
//   stall                  : combinational hold/bubble request
//   squash                 : ID instruction is wrong-path
//   busy_vec               : per-register pending-write bits
//   flags_pending          : a flag write is in flight
// Optional feature macro: FLAG_TRACK_EN enables flag tracking; when undefined
// flags_pending is 0 and is_branch / issue_sets_flags are ignored.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int WB_LAT     = DEFAULT_WB_LAT,
  parameter int SQUASH_CNT = DEFAULT_SQUASH_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_sets_flags,
  input  logic              src0_re,
  input  logic              src1_re,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic              is_branch,
  input  logic              redirect,
  input  logic              icache_stall,
  output logic              stall,
  output logic              squash,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic              flags_pending
);

  localparam int CNT_W = $clog2(SQUASH_CNT + 1);

  sb_entry_t            entry_in;
  sb_entry_t            slots [WB_LAT];
  logic                 accept;
  logic                 raw_hazard;
  logic                 flag_hazard;
  logic [CNT_W-1:0]     squash_cnt_q;
  logic [CNT_W-1:0]     squash_cnt_d;

  assign accept = issue_valid & ~stall & ~squash;

  // Non-accepted cycles push a bubble, so the line keeps ageing regardless.
  always_comb begin
    entry_in       = '0;
    entry_in.valid = accept;
    entry_in.we    = issue_we;
    entry_in.dst   = SB_DST_W'(issue_dst);
`ifdef FLAG_TRACK_EN
    entry_in.flags = issue_sets_flags;
`endif
  end

  hazard_delay_line #(
    .WB_LAT (WB_LAT)
  ) u_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .entry_in (entry_in),
    .slots    (slots)
  );

  // The oldest slot is still counted: the register file has no bypass, so the
  // value is not readable until that slot has shifted out.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < WB_LAT; i++) begin
        if (slots[i].valid && slots[i].we && (slots[i].dst == SB_DST_W'(r))) begin
          busy_vec[r] = 1'b1;
        end
      end
    end
  end

`ifdef FLAG_TRACK_EN
  always_comb begin
    flags_pending = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (slots[i].valid && slots[i].flags) begin
        flags_pending = 1'b1;
      end
    end
  end

  assign flag_hazard = is_branch & flags_pending;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = is_branch ^ issue_sets_flags;
  assign flags_pending      = 1'b0;
  assign flag_hazard        = 1'b0;
`endif

  assign raw_hazard = (src0_re & busy_vec[src0_addr]) | (src1_re & busy_vec[src1_addr]);

  // A squashed instruction is a bubble, so its operands cannot cause a hazard.
  assign stall = icache_stall | (issue_valid & ~squash & (raw_hazard | flag_hazard));

  // Redirects can only load via accept, which is blocked while squashing, so a
  // redirect inside the window never reloads. A fetch miss freezes the count.
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (squash_cnt_q != '0) begin
      if (!icache_stall) begin
        squash_cnt_d = squash_cnt_q - CNT_W'(1);
      end
    end else if (accept && redirect) begin
      squash_cnt_d = CNT_W'(SQUASH_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt_q <= '0;
    end else begin
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign squash = (squash_cnt_q != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed test of hazard_scoreboard with default parameters (16 regs,
// WB_LAT=4, SQUASH_CNT=3). Expectations for flag tracking follow the
// FLAG_TRACK_EN macro.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_we;
  logic [3:0]  issue_dst;
  logic        issue_sets_flags;
  logic        src0_re;
  logic        src1_re;
  logic [3:0]  src0_addr;
  logic [3:0]  src1_addr;
  logic        is_branch;
  logic        redirect;
  logic        icache_stall;
  logic        stall;
  logic        squash;
  logic [15:0] busy_vec;
  logic        flags_pending;

  int vectorCount;
  int missCount;
  logic expFlag;

  hazard_scoreboard dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid      (issue_valid),
    .issue_we         (issue_we),
    .issue_dst        (issue_dst),
    .issue_sets_flags (issue_sets_flags),
    .src0_re          (src0_re),
    .src1_re          (src1_re),
    .src0_addr        (src0_addr),
    .src1_addr        (src1_addr),
    .is_branch        (is_branch),
    .redirect         (redirect),
    .icache_stall     (icache_stall),
    .stall            (stall),
    .squash           (squash),
    .busy_vec         (busy_vec),
    .flags_pending    (flags_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge, then settles 1ns so
  // combinational outputs can be sampled well away from the rising edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] dst,
                               input logic sf, input logic r0, input logic [3:0] a0,
                               input logic r1, input logic [3:0] a1, input logic br,
                               input logic rd, input logic ic);
    @(negedge clk);
    issue_valid      = v;
    issue_we         = we;
    issue_dst        = dst;
    issue_sets_flags = sf;
    src0_re          = r0;
    src0_addr        = a0;
    src1_re          = r1;
    src1_addr        = a1;
    is_branch        = br;
    redirect         = rd;
    icache_stall     = ic;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
`ifdef FLAG_TRACK_EN
    expFlag = 1'b1;
`else
    expFlag = 1'b0;
`endif

    // Reset state, including stall following icache_stall under reset.
    rst_n = 1'b0;
    issue_valid = 0; issue_we = 0; issue_dst = 0; issue_sets_flags = 0;
    src0_re = 0; src1_re = 0; src0_addr = 0; src1_addr = 0;
    is_branch = 0; redirect = 0; icache_stall = 0;
    #2;
    checkOutput("rst_busy", 32'(busy_vec), 32'h0);
    checkOutput("rst_flags", 32'(flags_pending), 32'h0);
    checkOutput("rst_squash", 32'(squash), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    icache_stall = 1'b1;
    #1;
    checkOutput("rst_stall_ic", 32'(stall), 32'h1);
    icache_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // RAW: producer R3, then reader of R3 stalls 4 cycles, then goes.
    applyStimulus(1, 1, 4'd3, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    checkOutput("prod_stall", 32'(stall), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 4'd0, 0, 1, 4'd3, 0, 4'd0, 0, 0, 0);
      checkOutput($sformatf("raw_stall_%0d", i), 32'(stall), (i < 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("raw_busy_%0d", i), 32'(busy_vec), (i < 4) ? 32'h8 : 32'h0);
    end

    // No dependency: R3 pending, reader of R5 proceeds immediately.
    applyStimulus(1, 1, 4'd3, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 0, 0, 4'd0, 1, 4'd5, 0, 0, 0);
    checkOutput("nodep_stall", 32'(stall), 32'h0);
    checkOutput("nodep_busy", 32'(busy_vec), 32'h8);
    for (int i = 0; i < 3; i++) idle();
    checkOutput("nodep_busy_hold", 32'(busy_vec), 32'h8);
    idle();
    checkOutput("nodep_drain", 32'(busy_vec), 32'h0);

    // Flags: SUB writing R1 and flags, then a branch.
    applyStimulus(1, 1, 4'd1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    checkOutput("sub_stall", 32'(stall), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 1, 0, 0);
      checkOutput($sformatf("br_stall_%0d", i), 32'(stall), (i < 4) ? 32'(expFlag) : 32'h0);
      checkOutput($sformatf("br_flags_%0d", i), 32'(flags_pending), (i < 4) ? 32'(expFlag) : 32'h0);
    end
    checkOutput("br_busy_drain", 32'(busy_vec), 32'h0);

    // Redirect: 3 squashed slots; writes to R7 are dropped; re-redirect ignored.
    applyStimulus(1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    checkOutput("call_squash", 32'(squash), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'd7, 0, 0, 4'd0, 0, 4'd0, 0, (i == 1), 0);
      checkOutput($sformatf("sq_squash_%0d", i), 32'(squash), 32'h1);
      checkOutput($sformatf("sq_busy_%0d", i), 32'(busy_vec), 32'h0);
    end
    idle();
    checkOutput("sq_end", 32'(squash), 32'h0);
    checkOutput("sq_busy_end", 32'(busy_vec), 32'h0);

    // Fetch miss inside the squash window stretches it to 5 cycles.
    applyStimulus(1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 0, (i == 1 || i == 2));
      checkOutput($sformatf("ic_squash_%0d", i), 32'(squash), (i < 5) ? 32'h1 : 32'h0);
      checkOutput($sformatf("ic_stall_%0d", i), 32'(stall), (i == 1 || i == 2) ? 32'h1 : 32'h0);
    end

    // Asynchronous reset between edges with R3 pending and squash active.
    applyStimulus(1, 1, 4'd3, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    idle();
    checkOutput("mid_busy_pre", 32'(busy_vec), 32'h8);
    checkOutput("mid_squash_pre", 32'(squash), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_rst", 32'(busy_vec), 32'h0);
    checkOutput("mid_squash_rst", 32'(squash), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checkOutput("post_rst_busy", 32'(busy_vec), 32'h0);
    checkOutput("post_rst_squash", 32'(squash), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
